// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - checkers turn controller between cursor front end, move generator and board
//
// Purpose: turns debounced select pulses into a source pick and a destination pick,
// requests legal-move scans, commits moves over a req/ack handshake, follows multi-jump
// chains, alternates turns and latches the sticky win result.
//
// Optional feature macro: TURN_TIMEOUT_EN (per-turn time limit of TURN_CYCLES clocks).
//
// Ports:
//   clk           system clock (25 MHz)
//   rst           synchronous, active-high reset
//   sel_pulse     one-cycle debounced select event
//   cursor_loc    current cursor square (row*8 + col)
//   sq_owner      owner of cursor_loc: 00 empty, 01 red, 10 white
//   gen_start     one-cycle scan request
//   gen_mode      0 = single-source scan, 1 = whole-side scan
//   gen_src       source square for a single-source scan
//   gen_jump_only restrict the scan to captures
//   gen_done      one-cycle scan complete
//   gen_mask      legal destinations, valid with gen_done
//   gen_any       at least one legal move exists, valid with gen_done
//   gen_jump      at least one capture exists, valid with gen_done
//   mv_req        move commit request (level)
//   mv_src        move source, stable while mv_req is high
//   mv_dst        move destination, stable while mv_req is high
//   mv_ack        board applied the move (one cycle)
//   turn          1 = red, 0 = white
//   select_loc    locked source square
//   sel_valid     select_loc is meaningful
//   legal_mask    registered legal-destination overlay
//   red_win       sticky red win flag
//   white_win     sticky white win flag

module turn_sequencer #(
   parameter int SQ_W   = 6,
   parameter int MASK_W = 64
`ifdef TURN_TIMEOUT_EN
   ,
   parameter logic [31:0] TURN_CYCLES = 32'd750_000_000
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_pulse,
   input  logic [SQ_W-1:0]   cursor_loc,
   input  logic [1:0]        sq_owner,
   output logic              gen_start,
   output logic              gen_mode,
   output logic [SQ_W-1:0]   gen_src,
   output logic              gen_jump_only,
   input  logic              gen_done,
   input  logic [MASK_W-1:0] gen_mask,
   input  logic              gen_any,
   input  logic              gen_jump,
   output logic              mv_req,
   output logic [SQ_W-1:0]   mv_src,
   output logic [SQ_W-1:0]   mv_dst,
   input  logic              mv_ack,
   output logic              turn,
   output logic [SQ_W-1:0]   select_loc,
   output logic              sel_valid,
   output logic [MASK_W-1:0] legal_mask,
   output logic              red_win,
   output logic              white_win
);

   localparam int ROW_W = SQ_W - 3;

   typedef enum logic [2:0] {
      ST_SCAN     = 3'd0,
      ST_PICK_SRC = 3'd1,
      ST_GEN_SRC  = 3'd2,
      ST_PICK_DST = 3'd3,
      ST_COMMIT   = 3'd4,
      ST_SWITCH   = 3'd5,
      ST_OVER     = 3'd6
   } state_t;

   state_t state;
   logic   forced;
   logic   chain;
   logic   issued;   // scan request for the current SCAN/GEN_SRC visit already sent

   logic [1:0]       own_code;
   logic [ROW_W-1:0] src_row;
   logic [ROW_W-1:0] dst_row;
   logic [ROW_W-1:0] row_diff_fwd;
   logic [ROW_W-1:0] row_diff_bwd;
   logic             capture;
   logic             own_pick;

   always_comb begin
      own_code     = turn ? 2'b01 : 2'b10;
      own_pick     = sel_pulse && (sq_owner == own_code);
      src_row      = mv_src[SQ_W-1:3];
      dst_row      = mv_dst[SQ_W-1:3];
      row_diff_fwd = src_row - dst_row;
      row_diff_bwd = dst_row - src_row;
      // a capture jumps over exactly one row, in either direction (kings move both ways)
      capture      = (row_diff_fwd == ROW_W'(2)) || (row_diff_bwd == ROW_W'(2));
   end

`ifdef TURN_TIMEOUT_EN
   logic [31:0] turn_cnt;
   logic        timeout;

   assign timeout = (turn_cnt == TURN_CYCLES - 32'd1);

   always_ff @(posedge clk) begin
      if (rst || state == ST_SWITCH) begin
         turn_cnt <= 32'd0;
      end else if (state == ST_PICK_SRC || state == ST_GEN_SRC || state == ST_PICK_DST) begin
         turn_cnt <= turn_cnt + 32'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_SCAN;
         turn          <= 1'b1;
         gen_start     <= 1'b0;
         gen_mode      <= 1'b1;
         gen_src       <= '0;
         gen_jump_only <= 1'b0;
         mv_req        <= 1'b0;
         mv_src        <= '0;
         mv_dst        <= '0;
         select_loc    <= '0;
         sel_valid     <= 1'b0;
         legal_mask    <= '0;
         red_win       <= 1'b0;
         white_win     <= 1'b0;
         forced        <= 1'b0;
         chain         <= 1'b0;
         issued        <= 1'b0;
      end else begin
         gen_start <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (!issued) begin
                  gen_start     <= 1'b1;
                  gen_mode      <= 1'b1;
                  gen_jump_only <= 1'b0;
                  issued        <= 1'b1;
               end else if (gen_done) begin
                  if (!gen_any) begin
                     // side to move is blocked: opponent wins
                     if (turn) white_win <= 1'b1;
                     else      red_win   <= 1'b1;
                     state <= ST_OVER;
                  end else begin
                     forced <= gen_jump;
                     state  <= ST_PICK_SRC;
                  end
               end
            end

            ST_PICK_SRC: begin
`ifdef TURN_TIMEOUT_EN
               if (timeout && !chain) begin
                  if (turn) white_win <= 1'b1;
                  else      red_win   <= 1'b1;
                  state <= ST_OVER;
               end else if (timeout) begin
                  state <= ST_SWITCH;
               end else
`endif
               if (own_pick) begin
                  select_loc <= cursor_loc;
                  sel_valid  <= 1'b1;
                  issued     <= 1'b0;
                  state      <= ST_GEN_SRC;
               end
            end

            ST_GEN_SRC: begin
               if (!issued) begin
                  gen_start     <= 1'b1;
                  gen_mode      <= 1'b0;
                  gen_src       <= select_loc;
                  gen_jump_only <= forced | chain;
                  issued        <= 1'b1;
               end else if (gen_done) begin
                  if (gen_mask == '0) begin
                     if (chain) begin
                        state <= ST_SWITCH;
                     end else begin
                        sel_valid <= 1'b0;
                        state     <= ST_PICK_SRC;
                     end
                  end else begin
                     legal_mask <= gen_mask;
                     state      <= ST_PICK_DST;
                  end
               end
            end

            ST_PICK_DST: begin
`ifdef TURN_TIMEOUT_EN
               if (timeout && !chain) begin
                  if (turn) white_win <= 1'b1;
                  else      red_win   <= 1'b1;
                  state <= ST_OVER;
               end else if (timeout) begin
                  state <= ST_SWITCH;
               end else
`endif
               if (sel_pulse) begin
                  if (cursor_loc == select_loc && !chain) begin
                     sel_valid  <= 1'b0;
                     legal_mask <= '0;
                     state      <= ST_PICK_SRC;
                  end else if (legal_mask[cursor_loc]) begin
                     mv_src <= select_loc;
                     mv_dst <= cursor_loc;
                     mv_req <= 1'b1;
                     state  <= ST_COMMIT;
                  end
               end
            end

            ST_COMMIT: begin
               if (mv_ack) begin
                  mv_req <= 1'b0;
                  if (capture) begin
                     // continuation: the jumping piece must keep capturing if it can
                     chain      <= 1'b1;
                     select_loc <= mv_dst;
                     issued     <= 1'b0;
                     state      <= ST_GEN_SRC;
                  end else begin
                     state <= ST_SWITCH;
                  end
               end
            end

            ST_SWITCH: begin
               turn       <= ~turn;
               chain      <= 1'b0;
               sel_valid  <= 1'b0;
               legal_mask <= '0;
               issued     <= 1'b0;
               state      <= ST_SCAN;
            end

            ST_OVER: begin
               state <= ST_OVER;
            end

            default: begin
               state <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer

module tb_turn_sequencer;

   logic        clk;
   logic        rst;
   logic        sel_pulse;
   logic [5:0]  cursor_loc;
   logic [1:0]  sq_owner;
   logic        gen_start;
   logic        gen_mode;
   logic [5:0]  gen_src;
   logic        gen_jump_only;
   logic        gen_done;
   logic [63:0] gen_mask;
   logic        gen_any;
   logic        gen_jump;
   logic        mv_req;
   logic [5:0]  mv_src;
   logic [5:0]  mv_dst;
   logic        mv_ack;
   logic        turn;
   logic [5:0]  select_loc;
   logic        sel_valid;
   logic [63:0] legal_mask;
   logic        red_win;
   logic        white_win;

   int n_checks = 0;
   int n_errors = 0;

   turn_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .sel_pulse     (sel_pulse),
      .cursor_loc    (cursor_loc),
      .sq_owner      (sq_owner),
      .gen_start     (gen_start),
      .gen_mode      (gen_mode),
      .gen_src       (gen_src),
      .gen_jump_only (gen_jump_only),
      .gen_done      (gen_done),
      .gen_mask      (gen_mask),
      .gen_any       (gen_any),
      .gen_jump      (gen_jump),
      .mv_req        (mv_req),
      .mv_src        (mv_src),
      .mv_dst        (mv_dst),
      .mv_ack        (mv_ack),
      .turn          (turn),
      .select_loc    (select_loc),
      .sel_valid     (sel_valid),
      .legal_mask    (legal_mask),
      .red_win       (red_win),
      .white_win     (white_win)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit expired expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic select(input logic [5:0] sq, input logic [1:0] owner);
      cursor_loc = sq;
      sq_owner   = owner;
      sel_pulse  = 1'b1;
      tick();
      sel_pulse  = 1'b0;
   endtask

   task automatic scan_reply(input logic any, input logic jump, input logic [63:0] mask);
      gen_done = 1'b1;
      gen_any  = any;
      gen_jump = jump;
      gen_mask = mask;
      tick();
      gen_done = 1'b0;
      gen_any  = 1'b0;
      gen_jump = 1'b0;
      gen_mask = '0;
   endtask

   function automatic logic [63:0] bit_of(input int sq);
      logic [63:0] m;
      m = '0;
      m[sq] = 1'b1;
      return m;
   endfunction

   initial begin
      rst = 1'b1; sel_pulse = 1'b0; cursor_loc = '0; sq_owner = 2'b00;
      gen_done = 1'b0; gen_mask = '0; gen_any = 1'b0; gen_jump = 1'b0; mv_ack = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_turn", turn, 1);
      check("rst_gen_start", gen_start, 0);
      check("rst_mv_req", mv_req, 0);
      check("rst_sel_valid", sel_valid, 0);
      check("rst_select_loc", select_loc, 0);
      check("rst_legal_mask", legal_mask, 0);
      check("rst_mv_src", mv_src, 0);
      check("rst_mv_dst", mv_dst, 0);
      check("rst_red_win", red_win, 0);
      check("rst_white_win", white_win, 0);

      // red whole-side scan
      rst = 1'b0;
      tick();
      check("scan_start", gen_start, 1);
      check("scan_mode", gen_mode, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("scan_no_reissue", gen_start, 0);
      end
      scan_reply(1'b1, 1'b0, '0);

      // opponent and empty squares are ignored
      select(6'd20, 2'b10);
      tick();
      check("white_pick_start", gen_start, 0);
      check("white_pick_valid", sel_valid, 0);
      select(6'd19, 2'b00);
      tick();
      check("empty_pick_start", gen_start, 0);
      check("empty_pick_valid", sel_valid, 0);

      // own piece at 42: gen_start two cycles after the select
      select(6'd42, 2'b01);
      check("src_valid", sel_valid, 1);
      check("src_loc", select_loc, 42);
      check("src_start_early", gen_start, 0);
      tick();
      check("src_start", gen_start, 1);
      check("src_mode", gen_mode, 0);
      check("src_gen_src", gen_src, 42);
      check("src_jump_only", gen_jump_only, 0);
      scan_reply(1'b1, 1'b0, bit_of(33) | bit_of(35));
      check("dst_mask", legal_mask, bit_of(33) | bit_of(35));

      // reselect the source cancels
      select(6'd42, 2'b01);
      check("cancel_valid", sel_valid, 0);
      check("cancel_mask", legal_mask, 0);
      select(6'd42, 2'b01);
      tick();
      check("repick_start", gen_start, 1);
      scan_reply(1'b1, 1'b0, bit_of(33) | bit_of(35));

      // illegal destination ignored
      select(6'd50, 2'b00);
      tick();
      check("illegal_dst_req", mv_req, 0);
      check("illegal_dst_valid", sel_valid, 1);

      // commit 42 -> 33
      select(6'd33, 2'b00);
      check("commit_req", mv_req, 1);
      check("commit_src", mv_src, 42);
      check("commit_dst", mv_dst, 33);
      tick();
      tick();
      check("commit_hold", mv_req, 1);
      mv_ack = 1'b1;
      tick();
      mv_ack = 1'b0;
      check("ack_drop", mv_req, 0);
      check("ack_turn_pre", turn, 1);
      tick();
      check("switch_turn", turn, 0);
      check("switch_valid", sel_valid, 0);
      check("switch_mask", legal_mask, 0);
      tick();
      check("next_scan_start", gen_start, 1);
      check("next_scan_mode", gen_mode, 1);

      // white has no moves: red wins, sticky
      scan_reply(1'b0, 1'b0, '0);
      check("over_red_win", red_win, 1);
      check("over_white_win", white_win, 0);
      select(6'd21, 2'b10);
      tick();
      check("over_sel_start", gen_start, 0);
      check("over_sel_valid", sel_valid, 0);
      scan_reply(1'b1, 1'b0, '0);
      check("over_sticky", red_win, 1);
      check("over_turn", turn, 0);

      // reset clears the result; forced capture chain 42 -> 24 -> 10
      rst = 1'b1;
      tick();
      check("rst2_red_win", red_win, 0);
      check("rst2_turn", turn, 1);
      rst = 1'b0;
      tick();
      check("scan2_start", gen_start, 1);
      scan_reply(1'b1, 1'b1, '0);
      select(6'd42, 2'b01);
      tick();
      check("forced_start", gen_start, 1);
      check("forced_jump_only", gen_jump_only, 1);
      scan_reply(1'b1, 1'b1, bit_of(24));
      select(6'd24, 2'b00);
      check("jump1_src", mv_src, 42);
      check("jump1_dst", mv_dst, 24);
      mv_ack = 1'b1;
      tick();
      mv_ack = 1'b0;
      check("jump1_drop", mv_req, 0);
      tick();
      check("chain_start", gen_start, 1);
      check("chain_gen_src", gen_src, 24);
      check("chain_jump_only", gen_jump_only, 1);
      check("chain_select_loc", select_loc, 24);
      check("chain_turn", turn, 1);
      scan_reply(1'b1, 1'b1, bit_of(10));
      check("chain_mask", legal_mask, bit_of(10));
      select(6'd24, 2'b01);
      check("chain_nocancel_valid", sel_valid, 1);
      check("chain_nocancel_mask", legal_mask, bit_of(10));
      select(6'd10, 2'b00);
      check("jump2_req", mv_req, 1);
      check("jump2_src", mv_src, 24);
      check("jump2_dst", mv_dst, 10);
      mv_ack = 1'b1;
      tick();
      mv_ack = 1'b0;
      tick();
      check("chain2_start", gen_start, 1);
      check("chain2_gen_src", gen_src, 10);
      check("chain2_turn", turn, 1);
      scan_reply(1'b1, 1'b0, '0);
      check("chain_end_turn_pre", turn, 1);
      tick();
      check("chain_end_turn", turn, 0);
      check("chain_end_valid", sel_valid, 0);

      // white move in flight, then reset aborts it
      tick();
      check("white_scan_start", gen_start, 1);
      scan_reply(1'b1, 1'b0, '0);
      select(6'd21, 2'b10);
      tick();
      check("white_src_start", gen_start, 1);
      check("white_gen_src", gen_src, 21);
      scan_reply(1'b1, 1'b0, bit_of(28));
      select(6'd28, 2'b00);
      check("white_req", mv_req, 1);
      check("white_req_turn", turn, 0);
      rst = 1'b1;
      tick();
      check("abort_req", mv_req, 0);
      check("abort_turn", turn, 1);
      check("abort_valid", sel_valid, 0);
      check("abort_mask", legal_mask, 0);
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
